// File: rtl/pc_branch_ctrl.sv
// BIP-2 program-counter stage: PC register, branch-condition evaluation and HLT run/halt control.
// Optional taken-branch counter output branch_cnt_o is enabled by defining PC_BRANCH_CNT_EN.
module pc_branch_ctrl #(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [4:0]        opcode_i,
  input  logic [ADDR_W-1:0] operand_i,
  input  logic              z_i,
  input  logic              n_i,
  input  logic              resume_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] incrementer_o,
  output logic [ADDR_W-1:0] ext_o,
  output logic              branch_o,
  output logic              halted_o,
`ifdef PC_BRANCH_CNT_EN
  output logic [15:0]       branch_cnt_o,
`endif
  output logic              flush_o
);

  localparam logic [4:0] OP_HLT = 5'b00000;
  localparam logic [4:0] OP_BEQ = 5'b01000;
  localparam logic [4:0] OP_BNE = 5'b01001;
  localparam logic [4:0] OP_BGT = 5'b01010;
  localparam logic [4:0] OP_BGE = 5'b01011;
  localparam logic [4:0] OP_BLT = 5'b01100;
  localparam logic [4:0] OP_BLE = 5'b01101;
  localparam logic [4:0] OP_JMP = 5'b01110;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              flush_q, flush_d;
  logic              cond;
  logic              take;

  always_comb begin
    cond = 1'b0;
    case (opcode_i)
      OP_BEQ:  cond = z_i;
      OP_BNE:  cond = ~z_i;
      OP_BGT:  cond = ~z_i & ~n_i;
      OP_BGE:  cond = ~n_i;
      OP_BLT:  cond = n_i;
      OP_BLE:  cond = n_i | z_i;
      OP_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign branch_o      = cond & (state_q == ST_RUN);
  assign take          = (state_q == ST_RUN) & en_i & branch_o;
  assign incrementer_o = pc_q + ADDR_W'(1);
  assign ext_o         = operand_i;
  assign pc_o          = pc_q;
  assign halted_o      = halted_q;
  assign flush_o       = flush_q;

  // HLT leaves the PC on the HLT word; the resume edge itself never updates the PC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    flush_d  = take;
    case (state_q)
      ST_RUN: begin
        if (en_i) begin
          if (opcode_i == OP_HLT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_next_i;
          end
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_RUN;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      flush_q  <= flush_d;
    end
  end

`ifdef PC_BRANCH_CNT_EN
  logic [15:0] branch_cnt_q, branch_cnt_d;

  // Saturating count of taken-branch edges.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    if (take && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) branch_cnt_q <= 16'd0;
    else          branch_cnt_q <= branch_cnt_d;
  end

  assign branch_cnt_o = branch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed self-checking bench for pc_branch_ctrl; counter checks compile only with PC_BRANCH_CNT_EN.
module tb_pc_branch_ctrl;

  localparam int ADDR_W = 11;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_HLT = 5'b00000;
  localparam logic [4:0] OP_BEQ = 5'b01000;
  localparam logic [4:0] OP_BNE = 5'b01001;
  localparam logic [4:0] OP_BGT = 5'b01010;
  localparam logic [4:0] OP_BGE = 5'b01011;
  localparam logic [4:0] OP_BLT = 5'b01100;
  localparam logic [4:0] OP_BLE = 5'b01101;
  localparam logic [4:0] OP_JMP = 5'b01110;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [4:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              z, n, resume;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc, inc, ext;
  logic              branch, halted, flush;
  logic              use_loop;
  logic [ADDR_W-1:0] pc_force;
`ifdef PC_BRANCH_CNT_EN
  logic [15:0]       branch_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // External PC-select mux, or a forced value to position the PC.
  assign pc_next = use_loop ? (branch ? ext : inc) : pc_force;

  pc_branch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .opcode_i(opcode), .operand_i(operand),
    .z_i(z), .n_i(n), .resume_i(resume), .pc_next_i(pc_next),
    .pc_o(pc), .incrementer_o(inc), .ext_o(ext), .branch_o(branch), .halted_o(halted),
`ifdef PC_BRANCH_CNT_EN
    .branch_cnt_o(branch_cnt),
`endif
    .flush_o(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [ADDR_W-1:0] v);
    opcode   = OP_ADD;
    use_loop = 1'b0;
    pc_force = v;
    en       = 1'b1;
    step();
    check("set_pc", 32'(pc), 32'(v));
    use_loop = 1'b1;
  endtask

  logic [4:0] sweep_op [5];
  logic [2:0] sweep_exp [5];

  initial begin
    sweep_op[0] = OP_BGT; sweep_exp[0] = 3'b001;
    sweep_op[1] = OP_BGE; sweep_exp[1] = 3'b011;
    sweep_op[2] = OP_BLT; sweep_exp[2] = 3'b100;
    sweep_op[3] = OP_BLE; sweep_exp[3] = 3'b110;
    sweep_op[4] = OP_BNE; sweep_exp[4] = 3'b101;

    rst_n = 1'b0; en = 1'b1; opcode = OP_ADD; operand = '0; z = 1'b0; n = 1'b0;
    resume = 1'b0; use_loop = 1'b1; pc_force = '0;
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_inc", 32'(inc), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    step(); step();
    check("rst_hold_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(); check("seq_pc1", 32'(pc), 32'd1);
    step(); check("seq_pc2", 32'(pc), 32'd2);
    step(); check("seq_pc3", 32'(pc), 32'd3);

    // BEQ taken
    set_pc(11'd5);
    opcode = OP_BEQ; operand = 11'd8; z = 1'b1; #1;
    check("beq_t_branch", 32'(branch), 32'd1);
    check("beq_ext", 32'(ext), 32'd8);
    step();
    check("beq_t_pc", 32'(pc), 32'd8);
    check("beq_t_flush", 32'(flush), 32'd1);
    opcode = OP_ADD; step();
    check("beq_t_pc9", 32'(pc), 32'd9);
    check("beq_t_flush_end", 32'(flush), 32'd0);

    // BEQ not taken
    set_pc(11'd5);
    opcode = OP_BEQ; z = 1'b0; #1;
    check("beq_nt_branch", 32'(branch), 32'd0);
    step();
    check("beq_nt_pc", 32'(pc), 32'd6);
    check("beq_nt_flush", 32'(flush), 32'd0);

    // Flag sweep: (Z,N) = (0,0),(1,0),(0,1) map to bits 0,1,2 of sweep_exp
    set_pc(11'd10);
    operand = 11'd100; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opcode = sweep_op[i];
      z = 1'b0; n = 1'b0; #1; check($sformatf("sweep%0d_00", i), 32'(branch), 32'(sweep_exp[i][0]));
      z = 1'b1; n = 1'b0; #1; check($sformatf("sweep%0d_10", i), 32'(branch), 32'(sweep_exp[i][1]));
      z = 1'b0; n = 1'b1; #1; check($sformatf("sweep%0d_01", i), 32'(branch), 32'(sweep_exp[i][2]));
    end
    z = 1'b0; n = 1'b0;
    check("sweep_pc_held", 32'(pc), 32'd10);
    opcode = OP_JMP; z = 1'b1; n = 1'b1; en = 1'b1; #1;
    check("jmp_branch", 32'(branch), 32'd1);
    step();
    check("jmp_pc", 32'(pc), 32'd100);
    check("jmp_flush", 32'(flush), 32'd1);
    z = 1'b0; n = 1'b0;

    // Wrap and enable hold
    set_pc(11'd2047);
    check("wrap_flush", 32'(flush), 32'd0);
    check("wrap_inc", 32'(inc), 32'd0);
    step();
    check("wrap_pc", 32'(pc), 32'd0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("en0_hold%0d", i), 32'(pc), 32'd0);
    end
    en = 1'b1;

    // HALT
    set_pc(11'd7);
    opcode = OP_HLT; step();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_pc", 32'(pc), 32'd7);
    opcode = OP_JMP; operand = 11'd300; #1;
    check("hlt_branch", 32'(branch), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("halt_pc%0d", i), 32'(pc), 32'd7);
      check($sformatf("halt_br%0d", i), 32'(branch), 32'd0);
      check($sformatf("halt_fl%0d", i), 32'(flush), 32'd0);
    end
    resume = 1'b1; step(); resume = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_pc", 32'(pc), 32'd7);
    check("resume_flush", 32'(flush), 32'd0);
    opcode = OP_HLT; step();
    check("hlt2_halted", 32'(halted), 32'd1);
    check("hlt2_pc", 32'(pc), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_inc", 32'(inc), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = OP_ADD;
    step();
    check("postrst_pc", 32'(pc), 32'd1);

`ifdef PC_BRANCH_CNT_EN
    rst_n = 1'b0; #1;
    check("cnt_rst", 32'(branch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = OP_JMP; operand = 11'd50;
    step(); step(); step();
    opcode = OP_BEQ; z = 1'b0;
    step(); step();
    check("cnt_three", 32'(branch_cnt), 32'd3);
    opcode = OP_JMP;
    for (int i = 0; i < 65532; i++) @(posedge clk);
    #1;
    check("cnt_full", 32'(branch_cnt), 32'hFFFF);
    step();
    check("cnt_sat", 32'(branch_cnt), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter stage of the BIP-2 datapath. Holds the 11-bit PC, evaluates BIP-2 branch conditions against the STATUS flags, and drives the incrementer, branch-target and select inputs of the PC-select 2x1 mux. It registers the mux output back into the PC, so it sits directly upstream and downstream of that mux. It also implements the HLT run/halt control and a one-cycle fetch-flush pulse after taken branches.

## Interface
- `ADDR_W`, 11: PC and address width.
- `RESET_PC`, 0: PC value loaded at reset.

- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  advance enable; PC and FSM act only when 1.
- `opcode_i`  in  5  current instruction opcode.
- `operand_i`  in  ADDR_W  branch/jump target field.
- `z_i`  in  1  STATUS zero flag.
- `n_i`  in  1  STATUS negative flag.
- `resume_i`  in  1  leave HALT.
- `pc_next_i`  in  ADDR_W  PC-select mux output.
- `pc_o`  out  ADDR_W  current PC (registered).
- `incrementer_o`  out  ADDR_W  pc_o+1 mod 2^ADDR_W (combinational).
- `ext_o`  out  ADDR_W  branch target = operand_i (combinational).
- `branch_o`  out  1  mux select; 1 = take ext_o (combinational).
- `halted_o`  out  1  1 while in HALT (registered).
- `flush_o`  out  1  one-cycle pulse after a taken branch (registered).

## Operation
- Opcodes: HLT 00000, BEQ 01000, BNE 01001, BGT 01010, BGE 01011, BLT 01100, BLE 01101, JMP 01110. All other opcodes are non-branch.
- Conditions:
  - BEQ: Z.
  - BNE: !Z.
  - BGT: !Z & !N.
  - BGE: !N.
  - BLT: N.
  - BLE: N | Z.
  - JMP: always.
- `branch_o` = condition true & state==RUN. It is 0 in HALT regardless of opcode.
- FSM states: RUN (reset state) and HALT.
  - RUN, en_i=1, opcode HLT: go to HALT. PC is not updated; it still addresses the HLT word.
  - RUN, en_i=1, other opcode: pc_o <= pc_next_i.
  - RUN, en_i=0: hold everything.
  - HALT: PC held. resume_i=1 moves to RUN next cycle, with PC unchanged and no PC update in that same cycle. en_i is ignored in HALT.
- `flush_o` = 1 for the cycle after any edge where RUN & en_i & branch_o. It is 0 otherwise.
- Arithmetic: incrementer wraps, so 2047+1 = 0. There is no overflow flag.
- The block does not check that pc_next_i equals the mux function. It registers whatever value arrives.

## Timing
- Reset (async, on rst_n_i low):
  - pc_o = RESET_PC.
  - State RUN, halted_o = 0, flush_o = 0.
  - Combinational outputs follow, so incrementer_o = RESET_PC+1.
- Reset asserted mid-operation, including in HALT or while flush_o=1: outputs go to reset values immediately, not at the next clock. Operation restarts on the first edge after deassertion.
- PC update latency: pc_next_i is sampled at edge k and is visible on pc_o after edge k.
- halted_o rises the cycle after HLT is accepted and falls the cycle after resume_i is sampled.
- If resume_i and en_i are both high in HALT, only the resume is acted on.
- Combinational path: opcode_i/z_i/n_i to branch_o and the mux select to pc_next_i has no register. Flags must be stable before the edge.

## Configuration
- `PC_BRANCH_CNT_EN` defined:
  - Adds output `branch_cnt_o` [15:0], reset to 0.
  - Increments on each taken-branch edge (the same condition that schedules flush_o).
  - Saturates at 16'hFFFF.
- Not defined: the port and counter do not exist, and the behaviour of everything else is identical.

## Test plan
- Reset with RESET_PC=0 -> pc_o=0, incrementer_o=1, halted_o=0, flush_o=0. Release, feed the mux loop with opcode ADD for 3 cycles -> pc_o = 1, 2, 3.
- PC=5, opcode BEQ, operand 11'd8: with z_i=1 -> branch_o=1, pc_o=8 next, flush_o=1 for one cycle. With z_i=0 -> branch_o=0, pc_o=6, flush_o=0.
- Flag sweep at PC=10, target 100: BGT/BGE/BLT/BLE/BNE with (Z,N) = (0,0), (1,0), (0,1) -> branch_o matches the condition table. JMP -> always 100.
- PC=2047, opcode ADD -> pc_o=0 (wrap). en_i=0 for 4 cycles -> pc_o held at 0.
- HLT at PC=7 -> halted_o=1 next cycle, pc_o stays 7 for 10 cycles with en_i=1 and branch_o=0. resume_i pulse -> halted_o=0, pc_o=7. Assert rst_n_i low mid-HALT -> pc_o=0 and halted_o=0 immediately.
- With PC_BRANCH_CNT_EN: 3 taken plus 2 not-taken branches -> branch_cnt_o=3. Force the count to 16'hFFFF, then one more taken branch -> branch_cnt_o stays 16'hFFFF.
